// File: rtl/thread_fetch_seq.sv
// Four-thread round-robin instruction-fetch sequencer: drives the FETCH request handshake,
// buffers returned words in a small FIFO toward decode, and handles PC redirects and 0xF-window faults.
module thread_fetch_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  thread_en,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_thread,
    input  logic [31:0] redirect_pc,
    output logic        f_enable,
    output logic        write_mode,
    output logic [31:0] addr,
    output logic [31:0] data_i,
    output logic [1:0]  thread,
    input  logic [31:0] f_data,
    input  logic        f_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  instr_thread,
    output logic [3:0]  fault
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;

    logic [1:0]          state;
    logic [31:0]         pc [4];
    logic [1:0]          last;
    logic                killed;
    logic [31:0]         mem_data [FIFO_DEPTH];
    logic [31:0]         mem_pc   [FIFO_DEPTH];
    logic [1:0]          mem_thr  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_kill;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    logic [3:0]  elig;
    logic        found;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        pick_fault;
    logic        can_issue;
    logic        redir_hit;
    logic        drop;
    logic        push;
    logic        pop;
    logic        head_kill;

    assign write_mode = 1'b0;
    assign data_i     = 32'h0;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            elig[n] = thread_en[n] && !fault[n] && !(redirect_valid && redirect_thread == 2'(n));
        end
    end

    // Round-robin search starting just after the last issued thread.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_fault = (pc[pick][31:28] == 4'hF);
    assign can_issue  = (state == IDLE) && found && !pick_fault && (count < DEPTH_C);
    assign redir_hit  = redirect_valid && (redirect_thread == thread);
    assign drop       = killed || redir_hit;
    assign push       = (state == REQ) && f_ack && !drop;

    assign head_kill    = mem_kill[rd_ptr];
    assign instr_valid  = (count != '0) && !head_kill;
    assign pop          = (count != '0) && (head_kill || instr_ready);
    assign instr        = instr_valid ? mem_data[rd_ptr] : 32'h0;
    assign instr_pc     = instr_valid ? mem_pc[rd_ptr]   : 32'h0;
    assign instr_thread = instr_valid ? mem_thr[rd_ptr]  : 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            f_enable <= 1'b0;
            addr     <= 32'h0;
            thread   <= 2'd0;
            last     <= 2'd3;
            killed   <= 1'b0;
            fault    <= 4'h0;
            for (int n = 0; n < 4; n++) pc[n] <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_kill <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found && pick_fault) begin
                        fault[pick] <= 1'b1;
                    end else if (can_issue) begin
                        addr     <= pc[pick];
                        thread   <= pick;
                        f_enable <= 1'b1;
                        killed   <= 1'b0;
                        last     <= pick;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (redir_hit) killed <= 1'b1;
                    if (f_ack) begin
                        f_enable <= 1'b0;
                        state    <= REL;
                        if (!drop) pc[thread] <= pc[thread] + 32'd4;
                    end
                end
                REL: begin
                    if (!f_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Redirect is applied last so it overrides a same-cycle increment.
            if (redirect_valid) begin
                pc[redirect_thread]    <= {redirect_pc[31:2], 2'b00};
                fault[redirect_thread] <= 1'b0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (mem_thr[i] == redirect_thread) mem_kill[i] <= 1'b1;
                end
            end

            if (push) begin
                mem_kill[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= f_data;
            mem_pc[wr_ptr]   <= addr;
            mem_thr[wr_ptr]  <= thread;
        end
    end
endmodule
